// File: rtl/mpram_req_sched.sv
// Two-client request scheduler in front of a 2W/2R multiport memory: hazard
// arbitration on the combinational issue path, credit-limited reads, per-client response FIFOs.

module mpram_rsp_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_acc,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rd_ok
);
  localparam int STAGES = 1;
  localparam int CW     = $clog2(RSP_DEPTH + 1);
  localparam int PW     = $clog2(RSP_DEPTH);

  logic [STAGES:1]                       vld_q;
  logic [STAGES:0]                       vld_pipe;
  logic [CW-1:0]                         credit, count;
  logic [PW-1:0]                         wptr, rptr;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0]  buf_q;
  logic                                  push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign vld_pipe  = {vld_q, rd_acc};
  assign push      = vld_pipe[STAGES];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = buf_q[rptr];
  // Credits cover in-flight plus buffered reads, so a sampled dOut always has a slot.
  assign rd_ok     = (credit < CW'(RSP_DEPTH)) || ((credit == CW'(RSP_DEPTH)) && pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      credit <= '0;
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      vld_q  <= vld_pipe[STAGES-1:0];
      credit <= credit + CW'(rd_acc) - CW'(pop);
      count  <= count + CW'(push) - CW'(pop);
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wptr] <= mem_dout;
  end
endmodule

module mpram_req_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [1:0][DATA_WIDTH-1:0] rsp_data,
  output logic [1:0][ADDR_WIDTH-1:0] mem_rdAddr,
  output logic [1:0][ADDR_WIDTH-1:0] mem_wrAddr,
  output logic [1:0]                 mem_wren,
  output logic [1:0][DATA_WIDTH-1:0] mem_dIn,
  input  logic [1:0][DATA_WIDTH-1:0] mem_dOut,
  output logic [15:0]                conflict_cnt
);
  localparam int NUM_LANES = 2;

  logic                 addr_eq, ww_hit, pri;
  logic [NUM_LANES-1:0] rw_stall, rd_ok, wr_ok, acc, rd_acc;
  logic [1:0]           inc;
  logic [16:0]          cnt_sum;
  logic [15:0]          cnt_q;

  assign addr_eq = (req_addr[0] == req_addr[1]);
  assign ww_hit  = (&req_valid) & (&req_we) & addr_eq;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam int   O  = NUM_LANES - 1 - k;
    localparam logic KB = (k != 0);

    // A read colliding with the other client's write yields so the write lands first.
    assign rw_stall[k]  = req_valid[k] & ~req_we[k] & req_valid[O] & req_we[O] & addr_eq;
    assign wr_ok[k]     = ~(ww_hit & (pri != KB));
    assign req_ready[k] = ~reset & (req_we[k] ? wr_ok[k] : (rd_ok[k] & ~rw_stall[k]));
    assign acc[k]       = req_valid[k] & req_ready[k];
    assign rd_acc[k]    = acc[k] & ~req_we[k];
    assign mem_wren[k]  = acc[k] & req_we[k];
    assign mem_wrAddr[k] = req_addr[k];
    assign mem_dIn[k]    = req_wdata[k];
    assign mem_rdAddr[k] = req_addr[k];

    mpram_rsp_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .RSP_DEPTH (RSP_DEPTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .rd_acc   (rd_acc[k]),
      .mem_dout (mem_dOut[k]),
      .rsp_ready(rsp_ready[k]),
      .rsp_valid(rsp_valid[k]),
      .rsp_data (rsp_data[k]),
      .rd_ok    (rd_ok[k])
    );
  end

  assign inc     = 2'(ww_hit) + 2'(rw_stall[0]) + 2'(rw_stall[1]);
  assign cnt_sum = {1'b0, cnt_q} + 17'(inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pri   <= 1'b0;
    end else begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      if (ww_hit) pri <= ~pri;
    end
  end

  assign conflict_cnt = cnt_q;
endmodule
